// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and the legal WIDTH range.
package serial_adder_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// 1-bit combinational full adder cell driven by the serial adder each cycle.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: a + b + cin over WIDTH cycles, LSB first, through one full-adder cell.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of legal range");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c_q   <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c_q   <= cin;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    s_sh <= {fa_s, s_sh[WIDTH-1:1]};
                    c_q  <= fa_co;
                    cnt  <= cnt + CW'(1);
                    // Final bit goes straight into the result, not via s_sh.
                    if (cnt == LAST) begin
                        sum   <= {fa_s, s_sh[WIDTH-1:1]};
                        cout  <= fa_co;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed scenarios plus a WIDTH=4 exhaustive sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8;
    logic [7:0] a8, b8, sum8;
    logic       ready8, busy8, done8, cout8;

    logic       start4, cin4;
    logic [3:0] a4, b4, sum4;
    logic       ready4, busy4, done4, cout4;

    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt4 = 0;

    logic [8:0] sb8[$];
    logic [4:0] sb4[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always @(posedge clk) if (done4) done_cnt4 <= done_cnt4 + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input logic [7:0] ai, input logic [7:0] bi, input logic ci);
        a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
        sb8.push_back({1'b0, ai} + {1'b0, bi} + {8'd0, ci});
        step();
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            step();
            if (done8) begin
                seen = 1'b1;
                lat  = k;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        step(); step();
        rst_n = 1'b1;
        n_cmp++; if ({ready8, busy8, done8} !== 3'b100) begin n_err++; $display("FAIL reset_flags8 got %b want 100", {ready8, busy8, done8}); end
        n_cmp++; if ({cout8, sum8} !== 9'd0) begin n_err++; $display("FAIL reset_result8 got %h want 000", {cout8, sum8}); end
        n_cmp++; if ({ready4, busy4, done4} !== 3'b100) begin n_err++; $display("FAIL reset_flags4 got %b want 100", {ready4, busy4, done4}); end
        n_cmp++; if ({cout4, sum4} !== 5'd0) begin n_err++; $display("FAIL reset_result4 got %h want 00", {cout4, sum4}); end
    endtask

    task automatic test_basic();
        bit seen; int lat; logic [8:0] exp;
        issue8(8'h5A, 8'h3C, 1'b0);
        n_cmp++; if ({ready8, busy8} !== 2'b01) begin n_err++; $display("FAIL basic_busy got %b want 01", {ready8, busy8}); end
        wait_done8(seen, lat);
        exp = sb8.pop_front();
        n_cmp++; if (!seen) begin n_err++; $display("FAIL basic_done_timeout got none want done"); end
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL basic_latency got %0d want 8", lat); end
        n_cmp++; if ({cout8, sum8} !== exp) begin n_err++; $display("FAIL basic_result got %h want %h", {cout8, sum8}, exp); end
        n_cmp++; if ({cout8, sum8} !== 9'h096) begin n_err++; $display("FAIL basic_const got %h want 096", {cout8, sum8}); end
        step();
        n_cmp++; if ({ready8, busy8, done8} !== 3'b100) begin n_err++; $display("FAIL basic_pulse_end got %b want 100", {ready8, busy8, done8}); end
        n_cmp++; if ({cout8, sum8} !== 9'h096) begin n_err++; $display("FAIL basic_hold got %h want 096", {cout8, sum8}); end
    endtask

    task automatic test_carry();
        bit seen; int lat; logic [8:0] exp;
        issue8(8'hFF, 8'h01, 1'b0);
        wait_done8(seen, lat);
        exp = sb8.pop_front();
        n_cmp++; if (!seen || {cout8, sum8} !== exp) begin n_err++; $display("FAIL carry_ff01 got %h want %h seen=%0d", {cout8, sum8}, exp, seen); end
        n_cmp++; if ({cout8, sum8} !== 9'h100) begin n_err++; $display("FAIL carry_ff01_const got %h want 100", {cout8, sum8}); end
        step();
        issue8(8'hFF, 8'hFF, 1'b1);
        wait_done8(seen, lat);
        exp = sb8.pop_front();
        n_cmp++; if (!seen || {cout8, sum8} !== exp) begin n_err++; $display("FAIL carry_ffff1 got %h want %h seen=%0d", {cout8, sum8}, exp, seen); end
        n_cmp++; if ({cout8, sum8} !== 9'h1FF) begin n_err++; $display("FAIL carry_ffff1_const got %h want 1ff", {cout8, sum8}); end
        step();
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int overlap = 0;
        int d_edge[2] = '{0, 0};
        logic [8:0] exp;
        start8 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            if (ready8) sb8.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
            step();
            if (ready8 && busy8) overlap++;
            if (done8) begin
                exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h0;
                n_cmp++; if ({cout8, sum8} !== exp) begin n_err++; $display("FAIL b2b_result edge %0d got %h want %h", i, {cout8, sum8}, exp); end
                if (n_done < 2) d_edge[n_done] = i;
                n_done++;
            end
        end
        start8 = 1'b0;
        // Accept at edge 1, result at 1+8; DONE and IDLE each take a cycle, so next accept is edge 11.
        n_cmp++; if (n_done !== 2) begin n_err++; $display("FAIL b2b_done_count got %0d want 2", n_done); end
        n_cmp++; if (d_edge[0] !== 9) begin n_err++; $display("FAIL b2b_first_done got %0d want 9", d_edge[0]); end
        n_cmp++; if (d_edge[1] !== 19) begin n_err++; $display("FAIL b2b_second_done got %0d want 19", d_edge[1]); end
        n_cmp++; if (overlap !== 0) begin n_err++; $display("FAIL b2b_ready_busy_overlap got %0d want 0", overlap); end
        n_cmp++; if (sb8.size() !== 0) begin n_err++; $display("FAIL b2b_pending got %0d want 0", sb8.size()); end
        sb8.delete();
        step(); step();
    endtask

    task automatic test_reset_mid_run();
        bit seen; int lat; int stray = 0; logic [8:0] exp;
        issue8(8'hAA, 8'h55, 1'b1);
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb8.delete();
        n_cmp++; if ({ready8, busy8, done8} !== 3'b100) begin n_err++; $display("FAIL abort_flags got %b want 100", {ready8, busy8, done8}); end
        n_cmp++; if ({cout8, sum8} !== 9'd0) begin n_err++; $display("FAIL abort_result got %h want 000", {cout8, sum8}); end
        for (int k = 0; k < 12; k++) begin
            step();
            if (done8) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL abort_stray_done got %0d want 0", stray); end
        issue8(8'h12, 8'h34, 1'b1);
        wait_done8(seen, lat);
        exp = sb8.pop_front();
        n_cmp++; if (!seen || {cout8, sum8} !== exp) begin n_err++; $display("FAIL abort_next got %h want %h seen=%0d", {cout8, sum8}, exp, seen); end
        n_cmp++; if ({cout8, sum8} !== 9'h047) begin n_err++; $display("FAIL abort_next_const got %h want 047", {cout8, sum8}); end
        step();
    endtask

    task automatic test_sweep4();
        bit seen; logic [4:0] exp;
        int start_cnt = done_cnt4;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
                    sb4.push_back(5'(ai + bi + ci));
                    step();
                    start4 = 1'b0;
                    seen = 1'b0;
                    for (int k = 0; k < 20 && !seen; k++) begin
                        step();
                        if (done4) seen = 1'b1;
                    end
                    exp = sb4.pop_front();
                    n_cmp++; if (!seen || {cout4, sum4} !== exp) begin n_err++; $display("FAIL sweep4 a=%0d b=%0d c=%0d got %h want %h seen=%0d", ai, bi, ci, {cout4, sum4}, exp, seen); end
                    step();
                end
            end
        end
        step();
        n_cmp++; if (done_cnt4 - start_cnt !== 512) begin n_err++; $display("FAIL sweep4_done_count got %0d want 512", done_cnt4 - start_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
